// File: rtl/mem_arb_pkg.sv
// Shared types for the memory access arbiter: sequencer state encoding and wait-counter width.
package mem_arb_pkg;
    localparam int LAT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } arb_state_e;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction
endpackage

// File: rtl/mem_access_arbiter_if.sv
// Requester and memory-port bundle for mem_access_arbiter; index [n] belongs to requester n.
interface mem_access_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [1:0]             req;
    logic [1:0]             rw;
    logic [1:0][ADDR_W-1:0] addr;
    logic [1:0][DATA_W-1:0] wdata;
    logic [1:0]             grant;
    logic [1:0]             done;
    logic [1:0][DATA_W-1:0] rdata;
    logic                   mem_en;
    logic                   mem_wr;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_wdata;
    logic [DATA_W-1:0]      mem_rdata;
    logic                   busy;

    // master: the requesters plus the memory itself
    modport master (
        output req, rw, addr, wdata, mem_rdata,
        input  grant, done, rdata, mem_en, mem_wr, mem_addr, mem_wdata, busy
    );

    modport slave (
        input  req, rw, addr, wdata, mem_rdata,
        output grant, done, rdata, mem_en, mem_wr, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_access_arbiter_arb_rr2.sv
// arb_rr2: combinational two-request picker; round-robin on ptr, or requester 0 always
// wins a tie when MEM_ARB_FIXED_PRIO_EN is defined.
module arb_rr2 (
    input  logic req0,
    input  logic req1,
    input  logic ptr,
    output logic winner,
    output logic any
);
    assign any = req0 | req1;

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ptr;
    assign winner     = ~req0;
`else
    assign winner = (req0 & req1) ? ptr : req1;
`endif
endmodule

// File: rtl/mem_access_arbiter.sv
// Two-port arbiter/sequencer for the on-chip data memory: IDLE -> ISSUE -> WAIT(MEM_LAT) -> DONE.
// Build option MEM_ARB_FIXED_PRIO_EN replaces round-robin with fixed priority to requester 0.
module mem_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_access_arbiter_if.slave  bus
);
    localparam logic [LAT_W-1:0] LAT_LD = LAT_W'(MEM_LAT);

    arb_state_e       state_q, state_d;
    logic [LAT_W-1:0] cnt_q;
    logic             win_q, win_d, rw_q;
    logic             pick, any, ptr;
    logic             issue_go, last_wait;
    logic [1:0]       grant_d, done_d;
    logic             mem_en_d, mem_wr_d, busy_d;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign ptr = 1'b0;
`else
    logic ptr_q;
    assign ptr = ptr_q;

    // after a completed access the other requester gets first claim on a tie
    always_ff @(posedge clk) begin
        if (reset)                 ptr_q <= 1'b0;
        else if (state_q == DONE)  ptr_q <= ~win_q;
    end
`endif

    arb_rr2 u_pick (
        .req0   (bus.req[0]),
        .req1   (bus.req[1]),
        .ptr    (ptr),
        .winner (pick),
        .any    (any)
    );

    assign issue_go  = (state_q == IDLE) && any;
    assign last_wait = (state_q == WAIT) && (cnt_q == LAT_W'(1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (cnt_q == LAT_W'(1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // outputs are computed from the next state so the registered copies line up with state_q
    always_comb begin
        win_d    = issue_go ? pick : win_q;
        grant_d  = (state_d != IDLE) ? onehot2(win_d) : 2'b00;
        done_d   = (state_d == DONE) ? onehot2(win_q) : 2'b00;
        mem_en_d = issue_go;
        mem_wr_d = issue_go & bus.rw[pick];
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            win_q         <= 1'b0;
            rw_q          <= 1'b0;
            bus.grant     <= '0;
            bus.done      <= '0;
            bus.rdata     <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_wr    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.busy      <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            bus.grant  <= grant_d;
            bus.done   <= done_d;
            bus.mem_en <= mem_en_d;
            bus.mem_wr <= mem_wr_d;
            bus.busy   <= busy_d;
            // mem_addr/mem_wdata double as the latched request; requester inputs are free after this
            if (issue_go) begin
                rw_q          <= bus.rw[pick];
                bus.mem_addr  <= bus.addr[pick];
                bus.mem_wdata <= bus.wdata[pick];
            end
            if (state_q == ISSUE)     cnt_q <= LAT_LD;
            else if (state_q == WAIT) cnt_q <= cnt_q - LAT_W'(1);
            if (last_wait && !rw_q)   bus.rdata[win_q] <= bus.mem_rdata;
        end
    end
endmodule

// File: doc/mem_access_arbiter.md
# mem_access_arbiter

Two-port arbiter and sequencer for the single on-chip data memory. Two requesters share the memory: the serial command flow controller and a second master, such as the mode-1 streaming path. The block accepts one read or write at a time, drives the memory port, and waits a fixed memory latency. It then returns read data and a one-cycle completion pulse to the winning requester. Round-robin fairness is the default; fixed priority is a build option.

## Interface
Parameters:
- ADDR_W, 8, memory address width
- DATA_W, 8, memory data width
- MEM_LAT, 2, cycles from MemEn to valid MemRData; legal range 1..15

Ports:
- Clk  in  1  single clock, rising edge
- Reset  in  1  synchronous, active-high
- Req0 / Req1  in  1  access request per requester; held high until Done
- RW0 / RW1  in  1  0 = read, 1 = write
- Addr0 / Addr1  in  ADDR_W  access address
- WData0 / WData1  in  DATA_W  write data
- Grant0 / Grant1  out  1  requester owns the memory (ISSUE through DONE)
- Done0 / Done1  out  1  one-cycle completion pulse
- RData0 / RData1  out  DATA_W  read data; valid from Done, held until the next read completes for that port
- MemEn  out  1  memory strobe, one cycle per access
- MemWr  out  1  write enable, qualified by MemEn
- MemAddr  out  ADDR_W  memory address
- MemWData  out  DATA_W  memory write data
- MemRData  in  DATA_W  memory read data
- Busy  out  1  high whenever state is not IDLE

## Operation
- FSM states and transitions:
  - IDLE: moves to ISSUE if any Req is high.
  - ISSUE: exactly one cycle; moves to WAIT.
  - WAIT: lasts MEM_LAT cycles; moves to DONE.
  - DONE: exactly one cycle; moves to IDLE.
- Arbitration happens in IDLE only:
  - A single requester wins outright.
  - When both request, the winner is the one selected by the priority pointer `ptr`.
- On the IDLE→ISSUE edge, the block registers the winner index and the winner's RW, Addr and WData.
  - The requester's inputs are don't-care after this edge.
- ISSUE drives MemEn=1, MemWr=latched RW, and MemAddr/MemWData from the latched values.
- WAIT uses a 4-bit down-counter loaded with MEM_LAT.
  - On the last WAIT cycle, MemRData is registered into the winner's RData, for reads only.
  - For writes, RData is unchanged.
- DONE asserts the winner's Done for one cycle.
  - On the DONE→IDLE edge, `ptr` is set to point at the non-winner.
- GrantN is high from ISSUE through DONE inclusive.
- Req dropped mid-transaction: the transaction still completes and Done still pulses.
- Req still high in IDLE after Done is treated as a new request.
- Reset values, all outputs 0:
  - Grant, Done, MemEn, MemWr, MemAddr, MemWData, RData, Busy all 0.
  - `ptr` = 0, giving requester 0 first priority.
  - State = IDLE.
- Reset in any state aborts the transaction: no Done, memory strobe dropped on the next edge.

## Timing
- All outputs are registered.
- Request seen at cycle 0 (IDLE) produces:
  - MemEn at cycle 1.
  - WAIT during cycles 2..1+MEM_LAT.
  - Done at cycle 2+MEM_LAT.
  - IDLE at cycle 3+MEM_LAT.
- Back-to-back accesses: next MemEn no earlier than cycle 4+MEM_LAT.
- MEM_LAT=2 gives 4-cycle Req→Done latency and a 5-cycle access period.

## Configuration
- MEM_ARB_FIXED_PRIO_EN defined:
  - Requester 0 always wins simultaneous requests.
  - `ptr` logic is removed.
- Undefined (default): round-robin via `ptr` as above.

## Structure
- Shared package mem_arb_pkg holds:
  - The state enum (IDLE, ISSUE, WAIT, DONE).
  - The LAT_W=4 counter-width constant.
- One sub-module, arb_rr2: a combinational two-request picker.
  - Inputs: Req0, Req1, ptr.
  - Outputs: winner, any.
  - Fixed-priority mode is selected inside it by the macro.

## Test plan
- Read, MEM_LAT=2, after reset:
  - Stimulus: Req0 read Addr0=0x12 at cycle 0; memory returns 0xA5.
  - Response: MemEn=1, MemWr=0, MemAddr=0x12 at cycle 1; Done0 at cycle 4; RData0=0xA5; Grant1 never high.
- Write:
  - Stimulus: Req1 write Addr1=0x34, WData1=0x5C.
  - Response: MemEn=MemWr=1, MemAddr=0x34, MemWData=0x5C at cycle 1; Done1 at cycle 4; RData1 unchanged.
- Simultaneous requests, both held:
  - Round-robin build: grants alternate 0,1,0,1 with MemEn every 5 cycles.
  - MEM_ARB_FIXED_PRIO_EN build: all grants go to 0.
- Reset during WAIT:
  - Stimulus: Reset=1 for one cycle at cycle 2 of a read.
  - Response: no Done, all outputs 0 next cycle, Busy=0; next request is granted to requester 0.
- Req0 deasserted at cycle 2 mid-read:
  - Response: Done0 still pulses at cycle 4, RData0 updated, then IDLE with no new access.
